// File: rtl/ahb_bm_pkg.sv
// Shared definitions for the DMA bus matrix.
// Provides the AHB-Lite HTRANS and HRESP encodings and the default
// address / master-ID widths used by the matrix stages.
package ahb_bm_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int MAST_W_DEF = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

endpackage

// File: rtl/ahb_input_stage_dmam.sv
// Per-master input stage of the DMA bus matrix.
// Sits between one AHB-Lite master port and the decode/output stages. When
// no output stage can take the master's transfer, the address/control is
// kept in a holding register bank and presented as a pending transfer while
// the master is stalled. Once accepted, the slave's data-phase ready and
// response are relayed back to the master.
//
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   HSELS..HMASTLOCKS        master-side address/control
//   HREADYS                  bus-wide HREADY qualifying the address phase
//   active_in                some reachable output stage has selected this port
//   readyout_in, resp_in     data-phase ready/response from the owning output stage
//   sel_in..mastlock_in      address/control towards decoder/output stages
//   held_tran                a transfer is pending or presented this cycle
//   HREADYOUTS, HRESPS       ready/response back to the master
module ahb_input_stage_dmam
    import ahb_bm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int MAST_W = MAST_W_DEF
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic [MAST_W-1:0] HMASTERS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              active_in,
    input  logic              readyout_in,
    input  logic              resp_in,
    output logic              sel_in,
    output logic [ADDR_W-1:0] addr_in,
    output logic [1:0]        trans_in,
    output logic              write_in,
    output logic [2:0]        size_in,
    output logic [2:0]        burst_in,
    output logic [3:0]        prot_in,
    output logic [MAST_W-1:0] master_in,
    output logic              mastlock_in,
    output logic              held_tran,
    output logic              HREADYOUTS,
    output logic              HRESPS
);

    logic              sel_r;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        trans_r;
    logic              write_r;
    logic [2:0]        size_r;
    logic [2:0]        burst_r;
    logic [3:0]        prot_r;
    logic [MAST_W-1:0] master_r;
    logic              mastlock_r;
    logic              pend_tran_r;
    logic              dphase_r;

    logic              trans_req_s;
    logic              accept_s;
    logic              pend_next_s;
    logic              dphase_next_s;

    // Request qualification: only NONSEQ/SEQ in a valid address phase count.
    always_comb begin
        trans_req_s = HSELS & HTRANSS[1] & HREADYS;
        held_tran   = pend_tran_r | trans_req_s;
        accept_s    = held_tran & active_in & readyout_in;
    end

    // Holding bank captures every address phase; HREADYS low freezes it
    // while the master is stalled, so the pending copy stays intact.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_r      <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            trans_r    <= 2'b00;
            write_r    <= 1'b0;
            size_r     <= 3'b000;
            burst_r    <= 3'b000;
            prot_r     <= 4'b0000;
            master_r   <= {MAST_W{1'b0}};
            mastlock_r <= 1'b0;
        end else if (HREADYS) begin
            sel_r      <= HSELS;
            addr_r     <= HADDRS;
            trans_r    <= HTRANSS;
            write_r    <= HWRITES;
            size_r     <= HSIZES;
            burst_r    <= HBURSTS;
            prot_r     <= HPROTS;
            master_r   <= HMASTERS;
            mastlock_r <= HMASTLOCKS;
        end
    end

    // Next-state for the pending flag and the data-phase flag.
    always_comb begin
        pend_next_s   = held_tran & ~accept_s;
        dphase_next_s = dphase_r;
        if (accept_s) begin
            dphase_next_s = 1'b1;
        end else if (readyout_in) begin
            dphase_next_s = 1'b0;
        end else begin
            dphase_next_s = dphase_r;
        end
    end

    // State register for pending transfer and owned data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_tran_r <= 1'b0;
            dphase_r    <= 1'b0;
        end else begin
            pend_tran_r <= pend_next_s;
            dphase_r    <= dphase_next_s;
        end
    end

    // Address/control mux: the held copy wins while a transfer is pending,
    // which also keeps mastlock_in continuous across a stalled locked beat.
    always_comb begin
        if (pend_tran_r) begin
            sel_in      = sel_r;
            addr_in     = addr_r;
            trans_in    = trans_r;
            write_in    = write_r;
            size_in     = size_r;
            burst_in    = burst_r;
            prot_in     = prot_r;
            master_in   = master_r;
            mastlock_in = mastlock_r;
        end else begin
            sel_in      = HSELS;
            addr_in     = HADDRS;
            trans_in    = HTRANSS;
            write_in    = HWRITES;
            size_in     = HSIZES;
            burst_in    = HBURSTS;
            prot_in     = HPROTS;
            master_in   = HMASTERS;
            mastlock_in = HMASTLOCKS;
        end
    end

    // Master-facing ready/response: stall while pending, relay the slave
    // during an owned data phase (two-cycle ERROR passes through as-is).
    always_comb begin
        if (pend_tran_r) begin
            HREADYOUTS = 1'b0;
            HRESPS     = HRESP_OKAY;
        end else if (dphase_r) begin
            HREADYOUTS = readyout_in;
            HRESPS     = resp_in;
        end else begin
            HREADYOUTS = 1'b1;
            HRESPS     = HRESP_OKAY;
        end
    end

endmodule
